nf5_core: RTL and testbench



---
 rtl/nf5_core.sv | 253 +++++++++++++++++++++++++
 tb/tb_nf5_core.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf5_core.sv
// nf5_core: two-stage RV32I core (IF -> EX) with an embedded 16 KiB unified memory.
// The IF/ID register holds the fetched instruction and its PC (IFID_NowPC); EX decodes,
// executes, accesses memory and writes back in a single cycle, redirecting fetch with
// zero penalty on taken control transfers.
// Optional feature macro: CORE_HALT_ON_ILLEGAL_EN -- freeze fetch on an unknown opcode.

// Unified 4096x32 memory: two combinational read ports, one byte-enabled write port.
module nf5_dcache (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] fetch_idx,
   output logic [31:0] fetch_data,
   input  logic [11:0] load_idx,
   output logic [31:0] load_data,
   input  logic [11:0] store_idx,
   input  logic [3:0]  store_be,
   input  logic [31:0] store_data
);

   logic [31:0] data [0:4095];

   assign fetch_data = data[fetch_idx];
   assign load_data  = data[load_idx];

   // Byte-lane write; suppressed while reset is held so in-flight stores are dropped.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 4; k++) begin
            if (store_be[k]) data[store_idx][8*k +: 8] <= store_data[8*k +: 8];
         end
      end
   end

endmodule

module nf5_core (
   input logic clk,
   input logic rst_n
);

   localparam logic [31:0] InstrNop = 32'h0000_0013;

   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpReg    = 7'b0110011;
   localparam logic [6:0] OpFence  = 7'b0001111;
   localparam logic [6:0] OpSystem = 7'b1110011;

   logic [31:0] fetch_pc_q;
   logic [31:0] IFID_NowPC;
   logic [31:0] ifid_instr_q;
   logic        ifid_valid_q;
   logic [31:0] rf_q [0:31];

   logic [31:0] next_pc;
   logic [31:0] fetch_instr;
   logic [31:0] load_data;

   // Decode fields
   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1_val, rs2_val;

   // Execute results
   logic [31:0] alu_b, alu_res, mem_addr, load_val;
   logic [4:0]  shamt;
   logic        br_taken;
   logic        redirect;
   logic [31:0] target;
   logic        wb_en;
   logic [31:0] wb_data;
   logic [3:0]  store_be;
   logic [31:0] store_data;
   logic        halt;
   logic        unused_addr_bits;

   assign instr  = ifid_instr_q;
   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign f3     = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // x0 is reset to zero and never written, so it always reads zero.
   assign rs1_val = rf_q[rs1];
   assign rs2_val = rf_q[rs2];

   assign next_pc = redirect ? target : fetch_pc_q;

   assign mem_addr         = rs1_val + ((opcode == OpStore) ? imm_s : imm_i);
   assign unused_addr_bits = ^mem_addr[31:14];

   nf5_dcache i_Dcache (
      .clk        (clk),
      .rst_n      (rst_n),
      .fetch_idx  (next_pc[13:2]),
      .fetch_data (fetch_instr),
      .load_idx   (mem_addr[13:2]),
      .load_data  (load_data),
      .store_idx  (mem_addr[13:2]),
      .store_be   (store_be),
      .store_data (store_data)
   );

   // ALU shared by OP and OP-IMM; instr[30] selects SUB/SRA only where it is a funct7 bit.
   always_comb begin
      alu_b   = (opcode == OpReg) ? rs2_val : imm_i;
      shamt   = alu_b[4:0];
      alu_res = '0;
      case (f3)
         3'b000:  alu_res = (opcode == OpReg && instr[30]) ? rs1_val - alu_b : rs1_val + alu_b;
         3'b001:  alu_res = rs1_val << shamt;
         3'b010:  alu_res = {31'b0, $signed(rs1_val) < $signed(alu_b)};
         3'b011:  alu_res = {31'b0, rs1_val < alu_b};
         3'b100:  alu_res = rs1_val ^ alu_b;
         3'b101:  alu_res = instr[30] ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
         3'b110:  alu_res = rs1_val | alu_b;
         default: alu_res = rs1_val & alu_b;
      endcase
   end

   // Branch condition evaluation.
   always_comb begin
      case (f3)
         3'b000:  br_taken = rs1_val == rs2_val;
         3'b001:  br_taken = rs1_val != rs2_val;
         3'b100:  br_taken = $signed(rs1_val) < $signed(rs2_val);
         3'b101:  br_taken = $signed(rs1_val) >= $signed(rs2_val);
         3'b110:  br_taken = rs1_val < rs2_val;
         3'b111:  br_taken = rs1_val >= rs2_val;
         default: br_taken = 1'b0;
      endcase
   end

   // Load lane selection and extension.
   always_comb begin
      logic [7:0]  ld_byte;
      logic [15:0] ld_half;
      ld_byte = load_data[{mem_addr[1:0], 3'b000} +: 8];
      ld_half = load_data[{mem_addr[1], 4'b0000} +: 16];
      case (f3)
         3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
         3'b100:  load_val = {24'b0, ld_byte};
         3'b101:  load_val = {16'b0, ld_half};
         default: load_val = load_data;
      endcase
   end

   // Main decode: writeback, store enables, redirect and (optionally) halt.
   always_comb begin
      wb_en      = 1'b0;
      wb_data    = alu_res;
      redirect   = 1'b0;
      target     = IFID_NowPC + imm_j;
      store_be   = 4'b0000;
      store_data = rs2_val;
      halt       = 1'b0;
      if (ifid_valid_q) begin
         case (opcode)
            OpLui: begin
               wb_en   = 1'b1;
               wb_data = imm_u;
            end
            OpAuipc: begin
               wb_en   = 1'b1;
               wb_data = IFID_NowPC + imm_u;
            end
            OpJal: begin
               wb_en    = 1'b1;
               wb_data  = IFID_NowPC + 32'd4;
               redirect = 1'b1;
            end
            OpJalr: begin
               wb_en    = 1'b1;
               wb_data  = IFID_NowPC + 32'd4;
               redirect = 1'b1;
               target   = (rs1_val + imm_i) & ~32'd1;
            end
            OpBranch: begin
               redirect = br_taken;
               target   = IFID_NowPC + imm_b;
            end
            OpLoad: begin
               wb_en   = 1'b1;
               wb_data = load_val;
            end
            OpStore: begin
               case (f3)
                  3'b000: begin
                     store_be   = 4'b0001 << mem_addr[1:0];
                     store_data = {4{rs2_val[7:0]}};
                  end
                  3'b001: begin
                     store_be   = mem_addr[1] ? 4'b1100 : 4'b0011;
                     store_data = {2{rs2_val[15:0]}};
                  end
                  default: store_be = 4'b1111;
               endcase
            end
            OpImm, OpReg: wb_en = 1'b1;
            OpFence, OpSystem: ;
            default: begin
`ifdef CORE_HALT_ON_ILLEGAL_EN
               halt = 1'b1;
`else
               halt = 1'b0;
`endif
            end
         endcase
      end
   end

   // Fetch pipeline: IF/ID and FetchPC advance every cycle unless halted on an illegal op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q   <= '0;
         IFID_NowPC   <= '0;
         ifid_instr_q <= InstrNop;
         ifid_valid_q <= 1'b0;
      end else if (!halt) begin
         fetch_pc_q   <= next_pc + 32'd4;
         IFID_NowPC   <= next_pc;
         ifid_instr_q <= fetch_instr;
         ifid_valid_q <= 1'b1;
      end
   end

   // Register file writeback at the edge ending the EX cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else if (wb_en && rd != 5'd0) begin
         rf_q[rd] <= wb_data;
      end
   end

endmodule

// File: tb/tb_nf5_core.sv
// Directed self-checking bench for nf5_core: programs are hand-encoded into the memory
// through hierarchy, and PC trace / register / memory results are compared to constants.
module tb_nf5_core;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   nf5_core dut (
      .clk   (clk),
      .rst_n (rst_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction encoders
   function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
      logic [11:0] im;
      im = imm[11:0];
      return {im, rs1[4:0], f3[2:0], rd[4:0], op};
   endfunction

   function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
      logic [11:0] im;
      im = imm[11:0];
      return {im[11:5], rs2[4:0], rs1[4:0], f3[2:0], im[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
      logic [12:0] im;
      im = imm[12:0];
      return {im[12], im[10:5], rs2[4:0], rs1[4:0], f3[2:0], im[4:1], im[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_j(int imm, int rd);
      logic [20:0] im;
      im = imm[20:0];
      return {im[20], im[10:1], im[11], im[19:12], rd[4:0], 7'h6f};
   endfunction

   function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
   endfunction

   function automatic logic [31:0] enc_u(int imm20, int rd, logic [6:0] op);
      return {imm20[19:0], rd[4:0], op};
   endfunction

   task automatic put(int addr, logic [31:0] w);
      dut.i_Dcache.data[addr >> 2] = w;
   endtask

   // Hold reset and fill memory with NOPs.
   task automatic begin_load();
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < 4096; i++) dut.i_Dcache.data[i] = 32'h0000_0013;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic nonzero;
      begin_load();
      #2;
      n_checks++;
      if (dut.IFID_NowPC !== 32'h0) $display("FAIL reset_pc: got %h want %h", dut.IFID_NowPC, 32'h0);
      else n_pass++;
      n_checks++;
      if (dut.ifid_valid_q !== 1'b0) $display("FAIL reset_valid: got %b want 0", dut.ifid_valid_q);
      else n_pass++;
      n_checks++;
      if (dut.ifid_instr_q !== 32'h13) $display("FAIL reset_instr: got %h want 00000013", dut.ifid_instr_q);
      else n_pass++;
      nonzero = 1'b0;
      for (int i = 0; i < 32; i++) if (dut.rf_q[i] !== 32'h0) nonzero = 1'b1;
      n_checks++;
      if (nonzero !== 1'b0) $display("FAIL reset_regs: got nonzero=%b want 0", nonzero);
      else n_pass++;
      step();
      n_checks++;
      if (dut.IFID_NowPC !== 32'h0 || dut.ifid_valid_q !== 1'b0)
         $display("FAIL reset_hold: got pc=%h v=%b want 0/0", dut.IFID_NowPC, dut.ifid_valid_q);
      else n_pass++;
   endtask

   task automatic test_alu();
      logic [31:0] exp_pc [3];
      exp_pc = '{32'h0, 32'h4, 32'h8};
      begin_load();
      put(32'h00, enc_i(5, 0, 0, 1, 7'h13));
      put(32'h04, enc_i(-7, 1, 0, 2, 7'h13));
      put(32'h08, enc_i(3, 0, 0, 6, 7'h13));
      put(32'h0c, enc_i(1, 0, 0, 0, 7'h13));
      put(32'h10, enc_r(0, 0, 0, 0, 6));
      put(32'h14, enc_u(32'h80000, 7, 7'h37));
      put(32'h18, enc_i(32'h404, 7, 5, 8, 7'h13));
      put(32'h1c, enc_i(1, 0, 0, 9, 7'h13));
      put(32'h20, enc_i(-1, 0, 0, 10, 7'h13));
      put(32'h24, enc_r(0, 10, 9, 3, 11));
      put(32'h28, enc_j(0, 0));
      release_reset();
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (dut.IFID_NowPC !== exp_pc[i])
            $display("FAIL alu_pc[%0d]: got %h want %h", i, dut.IFID_NowPC, exp_pc[i]);
         else n_pass++;
      end
      n_checks++;
      if (dut.rf_q[1] !== 32'd5) $display("FAIL addi_x1: got %h want 00000005", dut.rf_q[1]);
      else n_pass++;
      step();
      n_checks++;
      if (dut.rf_q[2] !== 32'hFFFF_FFFE) $display("FAIL addi_x2: got %h want fffffffe", dut.rf_q[2]);
      else n_pass++;
      repeat (12) step();
      n_checks++;
      if (dut.rf_q[6] !== 32'h0) $display("FAIL x0_add: got %h want 00000000", dut.rf_q[6]);
      else n_pass++;
      n_checks++;
      if (dut.rf_q[8] !== 32'hF800_0000) $display("FAIL srai: got %h want f8000000", dut.rf_q[8]);
      else n_pass++;
      n_checks++;
      if (dut.rf_q[11] !== 32'h1) $display("FAIL sltu: got %h want 00000001", dut.rf_q[11]);
      else n_pass++;
      n_checks++;
      if (dut.IFID_NowPC !== 32'h28) $display("FAIL self_jump_a: got %h want 00000028", dut.IFID_NowPC);
      else n_pass++;
      step();
      n_checks++;
      if (dut.IFID_NowPC !== 32'h28) $display("FAIL self_jump_b: got %h want 00000028", dut.IFID_NowPC);
      else n_pass++;
      // Asynchronous reset in the middle of a cycle
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (dut.IFID_NowPC !== 32'h0 || dut.ifid_valid_q !== 1'b0 || dut.rf_q[1] !== 32'h0)
         $display("FAIL midreset: got pc=%h v=%b x1=%h want 0/0/0",
                  dut.IFID_NowPC, dut.ifid_valid_q, dut.rf_q[1]);
      else n_pass++;
   endtask

   task automatic test_mem();
      begin_load();
      put(32'h00, enc_u(32'h8899B, 1, 7'h37));
      put(32'h04, enc_i(-1349, 1, 0, 1, 7'h13));
      put(32'h08, enc_s(32'h100, 1, 0, 2));
      put(32'h0c, enc_i(32'h101, 0, 0, 3, 7'h03));
      put(32'h10, enc_i(32'h103, 0, 4, 4, 7'h03));
      put(32'h14, enc_i(32'h102, 0, 1, 5, 7'h03));
      put(32'h18, enc_i(32'h55, 0, 0, 13, 7'h13));
      put(32'h1c, enc_s(32'h202, 13, 0, 0));
      put(32'h20, enc_i(32'h200, 0, 2, 14, 7'h03));
      put(32'h24, enc_i(32'h102, 0, 5, 15, 7'h03));
      put(32'h28, enc_j(0, 0));
      put(32'h100, 32'h0);
      put(32'h200, 32'h0);
      release_reset();
      repeat (16) step();
      n_checks++;
      if (dut.i_Dcache.data[64] !== 32'h8899_AABB)
         $display("FAIL sw_word: got %h want 8899aabb", dut.i_Dcache.data[64]);
      else n_pass++;
      n_checks++;
      if (dut.rf_q[3] !== 32'hFFFF_FFAA) $display("FAIL lb: got %h want ffffffaa", dut.rf_q[3]);
      else n_pass++;
      n_checks++;
      if (dut.rf_q[4] !== 32'h88) $display("FAIL lbu: got %h want 00000088", dut.rf_q[4]);
      else n_pass++;
      n_checks++;
      if (dut.rf_q[5] !== 32'hFFFF_8899) $display("FAIL lh: got %h want ffff8899", dut.rf_q[5]);
      else n_pass++;
      n_checks++;
      if (dut.i_Dcache.data[128] !== 32'h0055_0000)
         $display("FAIL sb_word: got %h want 00550000", dut.i_Dcache.data[128]);
      else n_pass++;
      n_checks++;
      if (dut.rf_q[14] !== 32'h0055_0000) $display("FAIL lw_after_sb: got %h want 00550000", dut.rf_q[14]);
      else n_pass++;
      n_checks++;
      if (dut.rf_q[15] !== 32'h8899) $display("FAIL lhu: got %h want 00008899", dut.rf_q[15]);
      else n_pass++;
   endtask

   task automatic test_branch();
      logic [31:0] exp_pc [13];
      exp_pc = '{32'h00, 32'h04, 32'h08, 32'h0c, 32'h10, 32'h40, 32'h44,
                 32'h48, 32'h4c, 32'h50, 32'h70, 32'h80, 32'h80};
      begin_load();
      put(32'h00, enc_i(1, 0, 0, 1, 7'h13));
      put(32'h10, enc_b(32'h30, 0, 1, 1));
      put(32'h14, enc_i(9, 0, 0, 20, 7'h13));
      put(32'h40, enc_b(32'h100, 0, 1, 0));
      put(32'h44, enc_i(7, 0, 0, 21, 7'h13));
      put(32'h50, enc_j(32'h20, 1));
      put(32'h54, enc_i(1, 0, 0, 22, 7'h13));
      put(32'h70, enc_i(32'h81, 0, 0, 23, 7'h67));
      put(32'h74, enc_i(1, 0, 0, 24, 7'h13));
      put(32'h80, enc_j(0, 0));
      release_reset();
      for (int i = 0; i < 13; i++) begin
         step();
         n_checks++;
         if (dut.IFID_NowPC !== exp_pc[i])
            $display("FAIL branch_pc[%0d]: got %h want %h", i, dut.IFID_NowPC, exp_pc[i]);
         else n_pass++;
      end
      n_checks++;
      if (dut.rf_q[1] !== 32'h54) $display("FAIL jal_link: got %h want 00000054", dut.rf_q[1]);
      else n_pass++;
      n_checks++;
      if (dut.rf_q[23] !== 32'h74) $display("FAIL jalr_link: got %h want 00000074", dut.rf_q[23]);
      else n_pass++;
      n_checks++;
      if (dut.rf_q[21] !== 32'h7) $display("FAIL fallthrough: got %h want 00000007", dut.rf_q[21]);
      else n_pass++;
      n_checks++;
      if ((dut.rf_q[20] | dut.rf_q[22] | dut.rf_q[24]) !== 32'h0)
         $display("FAIL shadow_exec: got x20=%h x22=%h x24=%h want 0",
                  dut.rf_q[20], dut.rf_q[22], dut.rf_q[24]);
      else n_pass++;
   endtask

   task automatic test_pass_loop();
      logic [31:0] exp_pc [4];
      exp_pc = '{32'h0, 32'h5f0, 32'h5f4, 32'h5f8};
      begin_load();
      put(32'h00, enc_j(32'h5f0, 0));
      release_reset();
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if (dut.IFID_NowPC !== exp_pc[i])
            $display("FAIL pass_pc[%0d]: got %h want %h", i, dut.IFID_NowPC, exp_pc[i]);
         else n_pass++;
      end
   endtask

   task automatic test_illegal();
      logic [31:0] exp_pc [6];
      logic [31:0] exp_x2;
`ifdef CORE_HALT_ON_ILLEGAL_EN
      exp_pc = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'h8};
      exp_x2 = 32'h0;
`else
      exp_pc = '{32'h0, 32'h4, 32'h8, 32'hc, 32'h10, 32'h14};
      exp_x2 = 32'h2;
`endif
      begin_load();
      put(32'h04, enc_i(1, 0, 0, 1, 7'h13));
      put(32'h08, 32'hFFFF_FFFF);
      put(32'h0c, enc_i(2, 0, 0, 2, 7'h13));
      release_reset();
      for (int i = 0; i < 6; i++) begin
         step();
         n_checks++;
         if (dut.IFID_NowPC !== exp_pc[i])
            $display("FAIL illegal_pc[%0d]: got %h want %h", i, dut.IFID_NowPC, exp_pc[i]);
         else n_pass++;
      end
      n_checks++;
      if (dut.rf_q[1] !== 32'h1 || dut.rf_q[2] !== exp_x2)
         $display("FAIL illegal_regs: got x1=%h x2=%h want 1/%h", dut.rf_q[1], dut.rf_q[2], exp_x2);
      else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      test_reset();
      test_alu();
      test_mem();
      test_branch();
      test_pass_loop();
      test_illegal();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
